if_id_fetch_queue: RTL and testbench
====================================

Name: if_id_fetch_queue

Overview:
- Consumer end of the IF stage interface: accepts the fetched {pc, instr, valid} stream and presents it to ID through a valid/ready handshake.
- Drives the IF stage's control inputs (stall, branch/jump redirect), including an early redirect for JAL detected at enqueue.
- Absorbs the IF BRAM read latency with a small FIFO, so a stall raised by ID never loses in-flight words.
- Clears its contents on a pipeline flush and discards wrong-path words after any redirect.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥ SKID+2).
- SKID, 2, headroom kept free for words already in flight from IF when stall_o rises.
- SQUASH_N, 1, number of valid IF words discarded after each redirect (IF BRAM latency).
- XLEN, 32, PC/instruction width.

Ports:
- clk_i  in  1  clock, all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- if_valid_i  in  1  IF word valid (from IF valid_o).
- if_pc_i  in  XLEN  PC of the IF word.
- if_instr_i  in  32  instruction word.
- stall_o  out  1  to IF stall_i.
- take_bj_sig_o  out  1  to IF take_bj_sig_i, one-cycle pulse.
- pc_bj_o  out  XLEN  to IF pc_bj_i, valid while take_bj_sig_o=1.
- ex_redirect_i  in  1  EX mispredict/taken branch: flush and redirect.
- ex_pc_i  in  XLEN  EX redirect target.
- id_valid_o  out  1  head entry valid.
- id_pc_o  out  XLEN  head PC.
- id_instr_o  out  32  head instruction.
- id_ready_i  in  1  ID accepts the head this cycle.
- ovf_o  out  1  sticky overflow error.

Behaviour:
- Reset: FIFO empty, count=0, state RUN.
  - Outputs: stall_o=0, take_bj_sig_o=0, pc_bj_o=0, id_valid_o=0, id_pc_o=0, id_instr_o=0, ovf_o=0.
- FIFO structure:
  - Circular buffer with rd_ptr/wr_ptr of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count has log2(DEPTH)+1 bits.
- Output view: id_* shows the head entry combinationally. id_valid_o = (count≠0).
- Pop: id_valid_o & id_ready_i.
- Push: if_valid_i & state==RUN & no ex_redirect_i.
- Push and pop in the same cycle:
  - Allowed at any count, including full, in which case count is unchanged.
  - When empty, the pushed word appears on id_* the next cycle. There is no bypass, so latency is 1 cycle.
- Overflow: push with count==DEPTH and no pop drops the word and sets ovf_o; ovf_o is cleared only by reset.
- stall_o: registered, equal to (count_next ≥ DEPTH−SKID).
- Early JAL:
  - Trigger: a pushed word with instr[6:0]=7'b1101111.
  - The JAL itself is enqueued.
  - Next cycle: take_bj_sig_o=1 and pc_bj_o = pc + sign_extend({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}), wrapping modulo 2^XLEN.
  - State moves to SQUASH with squash_cnt=SQUASH_N.
- EX redirect (ex_redirect_i=1):
  - FIFO cleared (count=0, pointers reset), and any pop that cycle is ignored.
  - Next cycle: take_bj_sig_o=1, pc_bj_o=ex_pc_i.
  - State SQUASH, squash_cnt=SQUASH_N.
- FSM:
  - RUN→SQUASH on a JAL push or on ex_redirect_i.
  - SQUASH: each if_valid_i discards the word and decrements squash_cnt. At the last discard (cnt==1) → RUN; the next valid word is pushed normally.
  - Invalid IF cycles do not decrement squash_cnt.
- Priority:
  - ex_redirect_i beats a simultaneous JAL push: the JAL is not enqueued and pc_bj_o=ex_pc_i.
  - ex_redirect_i during SQUASH restarts squash_cnt=SQUASH_N.
- take_bj_sig_o is exactly one cycle wide; back-to-back redirects give consecutive pulses, the last one winning.
- Reset mid-operation discards all entries and any pending pulse.

Decomposition:
- Shared package rv32i_pkg: OPC_JAL=7'b1101111, XLEN, a J-immediate extraction function, and the fetch entry typedef {pc, instr}.
- One sub-module, sync_fifo (DEPTH, WIDTH), with push/pop/clear/count; the FSM, JAL detection and redirect logic stay in the top.

Test Plan:
- Stream, ID always ready: IF delivers pc 0x00,0x04,0x08 with instrs 0x00000013 → id_* shows each one cycle later in order; stall_o stays 0; count ≤1.
- Backpressure: id_ready_i=0 with IF streaming, DEPTH=4, SKID=2 → stall_o=1 once count reaches 2; words in flight still land; no ovf_o; draining restores order 0x00..0x0C.
- Early JAL: pc 0x0C, instr 0x010000EF (jal x1,+16) →
  - next cycle take_bj_sig_o=1, pc_bj_o=0x1C;
  - the word at pc 0x10 is discarded;
  - the next pushed word is pc 0x1C;
  - the JAL is delivered to ID.
- EX redirect with 3 entries queued and ex_pc_i=0x40 → id_valid_o=0 next cycle; take_bj_sig_o=1, pc_bj_o=0x40; one wrong-path word dropped; next entry pc 0x40.
- Simultaneous ex_redirect_i (target 0x80) and a JAL push → JAL not enqueued, pc_bj_o=0x80, single pulse.
- Forced overflow (stall_o ignored by the stimulus driving 6 words, ID not ready) → ovf_o=1 sticky; the first 4 words are intact; rst_i clears everything in one cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: JAL opcode, J-immediate
// extraction and the fetch entry layout used by IF/ID.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    // hi is instr[31:12]; result is the 21-bit J-immediate
    // {imm[20], imm[10:1], imm[11], imm[19:12], 0} reassembled.
    function automatic logic [20:0] j_imm(input logic [19:0] hi);
        return {hi[19], hi[7:0], hi[8], hi[18:9], 1'b0};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with push/pop/clear and occupancy count.
// Ports: clk_i, rst_i, push, pop, clear, wdata -> rdata, count,
// count_next, full, empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic [AW:0]      count_next,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign rdata = mem[rd_ptr];

    // A full FIFO still accepts a push when the head leaves
    // in the same cycle.
    always_comb begin
        do_pop  = pop & ~empty & ~clear;
        do_push = push & (~full | do_pop) & ~clear;
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   count_next = count + 1'b1;
                2'b01:   count_next = count - 1'b1;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count <= '0;
        else       count <= count_next;
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF->ID fetch queue: buffers fetched words, drives IF stall and
// redirects (early JAL, EX redirect), squashes wrong-path words.
// Ports: clk_i, rst_i; IF side if_valid_i/if_pc_i/if_instr_i,
// stall_o, take_bj_sig_o, pc_bj_o; EX side ex_redirect_i, ex_pc_i;
// ID side id_valid_o/id_pc_o/id_instr_o, id_ready_i; ovf_o.
module if_id_fetch_queue #(
    parameter int DEPTH    = 4,
    parameter int SKID     = 2,
    parameter int SQUASH_N = 1,
    parameter int XLEN     = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_valid_i,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [31:0]     if_instr_i,
    output logic            stall_o,
    output logic            take_bj_sig_o,
    output logic [XLEN-1:0] pc_bj_o,
    input  logic            ex_redirect_i,
    input  logic [XLEN-1:0] ex_pc_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [31:0]     id_instr_o,
    input  logic            id_ready_i,
    output logic            ovf_o
);

    import rv32i_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int EW = XLEN + 32;
    localparam int SW = $clog2(SQUASH_N + 1);

    localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - SKID);
    localparam logic [SW-1:0] SQ_INIT = SW'(SQUASH_N);
    localparam logic [SW-1:0] SQ_LAST = SW'(1);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [SW-1:0]   sq_cnt_q, sq_cnt_d;
    logic            stall_q;
    logic            take_q, take_d;
    logic [XLEN-1:0] pc_bj_q, pc_bj_d;
    logic            ovf_q;

    logic            push;
    logic            pop;
    logic            jal_push;
    logic [20:0]     imm;
    logic [XLEN-1:0] jal_tgt;

    logic [EW-1:0]   rdata;
    logic [AW:0]     count;
    logic [AW:0]     count_next;
    logic            full;
    logic            empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (push),
        .pop        (pop),
        .clear      (ex_redirect_i),
        .wdata      ({if_pc_i, if_instr_i}),
        .rdata      (rdata),
        .count      (count),
        .count_next (count_next),
        .full       (full),
        .empty      (empty)
    );

    assign imm     = j_imm(if_instr_i[31:12]);
    assign jal_tgt = if_pc_i + {{(XLEN-21){imm[20]}}, imm};

    always_comb begin
        push     = if_valid_i & (state_q == ST_RUN)
                 & ~ex_redirect_i;
        pop      = ~empty & id_ready_i & ~ex_redirect_i;
        jal_push = push & (if_instr_i[6:0] == OPC_JAL);
    end

    // jal_push already excludes ex_redirect_i, so the arms
    // are mutually exclusive and EX wins by construction.
    always_comb begin
        take_d  = 1'b0;
        pc_bj_d = pc_bj_q;
        unique case (1'b1)
            ex_redirect_i: begin
                take_d  = 1'b1;
                pc_bj_d = ex_pc_i;
            end
            jal_push: begin
                take_d  = 1'b1;
                pc_bj_d = jal_tgt;
            end
            default: ;
        endcase
    end

    // Only valid IF beats count toward the squash window.
    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        if (take_d) begin
            state_d  = ST_SQUASH;
            sq_cnt_d = SQ_INIT;
        end else if (state_q == ST_SQUASH && if_valid_i) begin
            sq_cnt_d = sq_cnt_q - 1'b1;
            if (sq_cnt_q == SQ_LAST) state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            sq_cnt_q <= '0;
            stall_q  <= 1'b0;
            take_q   <= 1'b0;
            pc_bj_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
            stall_q  <= (count_next >= STALL_TH);
            take_q   <= take_d;
            pc_bj_q  <= pc_bj_d;
            ovf_q    <= ovf_q | (push & full & ~pop);
        end
    end

    assign stall_o       = stall_q;
    assign take_bj_sig_o = take_q;
    assign pc_bj_o       = pc_bj_q;
    assign ovf_o         = ovf_q;

    assign id_valid_o = ~empty;
    assign id_pc_o    = empty ? '0 : rdata[EW-1:32];
    assign id_instr_o = empty ? '0 : rdata[31:0];

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue: table-driven
// vectors plus hand-written overflow and reset sequences.
module tb_if_id_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] JAL = 32'h0100_00EF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_instr_i;
    logic        stall_o;
    logic        take_bj_sig_o;
    logic [31:0] pc_bj_o;
    logic        ex_redirect_i;
    logic [31:0] ex_pc_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_ready_i;
    logic        ovf_o;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        val;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rdy;
        logic        exr;
        logic [31:0] expc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_stall;
        logic        e_take;
        logic [31:0] e_bj;
        logic        e_ovf;
    } vec_t;

    vec_t vq[$];

    if_id_fetch_queue dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .if_valid_i    (if_valid_i),
        .if_pc_i       (if_pc_i),
        .if_instr_i    (if_instr_i),
        .stall_o       (stall_o),
        .take_bj_sig_o (take_bj_sig_o),
        .pc_bj_o       (pc_bj_o),
        .ex_redirect_i (ex_redirect_i),
        .ex_pc_i       (ex_pc_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_instr_o    (id_instr_o),
        .id_ready_i    (id_ready_i),
        .ovf_o         (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic val,
                         input logic [31:0] pc,
                         input logic [31:0] instr,
                         input logic rdy,
                         input logic exr,
                         input logic [31:0] expc);
        if_valid_i    = val;
        if_pc_i       = pc;
        if_instr_i    = instr;
        id_ready_i    = rdy;
        ex_redirect_i = exr;
        ex_pc_i       = expc;
    endtask

    task automatic add(input logic val,
                       input logic [31:0] pc,
                       input logic [31:0] instr,
                       input logic rdy,
                       input logic exr,
                       input logic [31:0] expc,
                       input logic ev,
                       input logic [31:0] epc,
                       input logic [31:0] ein,
                       input logic est,
                       input logic etk,
                       input logic [31:0] ebj,
                       input logic eov);
        vec_t v;
        v.val = val; v.pc = pc; v.instr = instr;
        v.rdy = rdy; v.exr = exr; v.expc = expc;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = ein;
        v.e_stall = est; v.e_take = etk; v.e_bj = ebj;
        v.e_ovf = eov;
        vq.push_back(v);
    endtask

    initial begin
        // stream, ID always ready
        add(1, 'h00, NOP, 1, 0, 0, 1, 'h00, NOP, 0, 0, 0, 0);
        add(1, 'h04, NOP, 1, 0, 0, 1, 'h04, NOP, 0, 0, 0, 0);
        add(1, 'h08, NOP, 1, 0, 0, 1, 'h08, NOP, 0, 0, 0, 0);
        add(0, 'h00, NOP, 1, 0, 0, 0, 'h00, NOP, 0, 0, 0, 0);
        // backpressure
        add(1, 'h00, NOP, 0, 0, 0, 1, 'h00, NOP, 0, 0, 0, 0);
        add(1, 'h04, NOP, 0, 0, 0, 1, 'h00, NOP, 1, 0, 0, 0);
        add(1, 'h08, NOP, 0, 0, 0, 1, 'h00, NOP, 1, 0, 0, 0);
        add(1, 'h0C, NOP, 0, 0, 0, 1, 'h00, NOP, 1, 0, 0, 0);
        add(0, 'h00, NOP, 1, 0, 0, 1, 'h04, NOP, 1, 0, 0, 0);
        add(0, 'h00, NOP, 1, 0, 0, 1, 'h08, NOP, 1, 0, 0, 0);
        add(0, 'h00, NOP, 1, 0, 0, 1, 'h0C, NOP, 0, 0, 0, 0);
        add(0, 'h00, NOP, 1, 0, 0, 0, 'h00, NOP, 0, 0, 0, 0);
        // early JAL
        add(1, 'h0C, JAL, 1, 0, 0, 1, 'h0C, JAL, 0, 1, 'h1C, 0);
        add(1, 'h10, NOP, 1, 0, 0, 0, 'h00, NOP, 0, 0, 0, 0);
        add(1, 'h1C, NOP, 1, 0, 0, 1, 'h1C, NOP, 0, 0, 0, 0);
        add(0, 'h00, NOP, 1, 0, 0, 0, 'h00, NOP, 0, 0, 0, 0);
        // EX redirect with 3 queued
        add(1, 'h20, NOP, 0, 0, 0, 1, 'h20, NOP, 0, 0, 0, 0);
        add(1, 'h24, NOP, 0, 0, 0, 1, 'h20, NOP, 1, 0, 0, 0);
        add(1, 'h28, NOP, 0, 0, 0, 1, 'h20, NOP, 1, 0, 0, 0);
        add(1, 'h2C, NOP, 1, 1, 'h40,
            0, 'h00, NOP, 0, 1, 'h40, 0);
        add(1, 'h30, NOP, 1, 0, 0, 0, 'h00, NOP, 0, 0, 0, 0);
        add(1, 'h40, NOP, 1, 0, 0, 1, 'h40, NOP, 0, 0, 0, 0);
        add(0, 'h00, NOP, 1, 0, 0, 0, 'h00, NOP, 0, 0, 0, 0);
        // EX redirect beats simultaneous JAL push
        add(1, 'h50, JAL, 1, 1, 'h80,
            0, 'h00, NOP, 0, 1, 'h80, 0);
        add(1, 'h60, NOP, 1, 0, 0, 0, 'h00, NOP, 0, 0, 0, 0);
        add(1, 'h80, NOP, 1, 0, 0, 1, 'h80, NOP, 0, 0, 0, 0);
        add(0, 'h00, NOP, 1, 0, 0, 0, 'h00, NOP, 0, 0, 0, 0);
        // back-to-back redirects, last wins
        add(0, 'h00, NOP, 1, 1, 'h100,
            0, 'h00, NOP, 0, 1, 'h100, 0);
        add(1, 'h104, NOP, 1, 1, 'h200,
            0, 'h00, NOP, 0, 1, 'h200, 0);
        add(0, 'h00, NOP, 1, 0, 0, 0, 'h00, NOP, 0, 0, 0, 0);
        add(1, 'h104, NOP, 1, 0, 0, 0, 'h00, NOP, 0, 0, 0, 0);
        add(1, 'h200, NOP, 1, 0, 0, 1, 'h200, NOP, 0, 0, 0, 0);
        add(0, 'h00, NOP, 1, 0, 0, 0, 'h00, NOP, 0, 0, 0, 0);

        drive(0, 0, NOP, 0, 0, 0);
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_valid", 32'(id_valid_o), 0);
        chk("rst_pc", id_pc_o, 0);
        chk("rst_instr", id_instr_o, 0);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_take", 32'(take_bj_sig_o), 0);
        chk("rst_pc_bj", pc_bj_o, 0);
        chk("rst_ovf", 32'(ovf_o), 0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].val, vq[i].pc, vq[i].instr,
                  vq[i].rdy, vq[i].exr, vq[i].expc);
            tick();
            chk($sformatf("v%0d_valid", i),
                32'(id_valid_o), 32'(vq[i].e_valid));
            if (vq[i].e_valid) begin
                chk($sformatf("v%0d_pc", i),
                    id_pc_o, vq[i].e_pc);
                chk($sformatf("v%0d_instr", i),
                    id_instr_o, vq[i].e_instr);
            end
            chk($sformatf("v%0d_stall", i),
                32'(stall_o), 32'(vq[i].e_stall));
            chk($sformatf("v%0d_take", i),
                32'(take_bj_sig_o), 32'(vq[i].e_take));
            if (vq[i].e_take)
                chk($sformatf("v%0d_pc_bj", i),
                    pc_bj_o, vq[i].e_bj);
            chk($sformatf("v%0d_ovf", i),
                32'(ovf_o), 32'(vq[i].e_ovf));
        end

        // forced overflow: 6 words into a 4-entry queue
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h300 + 32'(i) * 4, NOP, 0, 0, 0);
            tick();
            if (i == 3) chk("ovf_at_full", 32'(ovf_o), 0);
        end
        chk("ovf_set", 32'(ovf_o), 1);
        chk("ovf_head", id_pc_o, 32'h300);
        drive(0, 0, NOP, 0, 0, 0);
        tick();
        tick();
        chk("ovf_sticky", 32'(ovf_o), 1);
        // push and pop at full keep count at 4
        drive(1, 32'h318, NOP, 1, 0, 0);
        tick();
        chk("full_pp_head", id_pc_o, 32'h304);
        chk("full_pp_stall", 32'(stall_o), 1);
        drive(0, 0, NOP, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_pc;
            exp_pc = (i == 3) ? 32'h318 : 32'h304 + 32'(i) * 4;
            chk($sformatf("drain%0d_valid", i),
                32'(id_valid_o), 1);
            chk($sformatf("drain%0d_pc", i), id_pc_o, exp_pc);
            tick();
        end
        chk("drain_empty", 32'(id_valid_o), 0);
        chk("drain_ovf", 32'(ovf_o), 1);

        // reset clears everything in one cycle
        drive(1, 32'h400, NOP, 0, 0, 0);
        tick();
        drive(1, 32'h404, JAL, 0, 0, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        drive(0, 0, NOP, 0, 0, 0);
        chk("rst2_valid", 32'(id_valid_o), 0);
        chk("rst2_take", 32'(take_bj_sig_o), 0);
        chk("rst2_pc_bj", pc_bj_o, 0);
        chk("rst2_ovf", 32'(ovf_o), 0);
        chk("rst2_stall", 32'(stall_o), 0);
        tick();
        chk("rst2_take_after", 32'(take_bj_sig_o), 0);
        // after reset the queue is back in RUN and accepts words
        drive(1, 32'h500, NOP, 1, 0, 0);
        tick();
        chk("rst2_run_pc", id_pc_o, 32'h500);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
